// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: assigns MIDI note-on/off events to voices.
// It scans one voice per cycle, then commits as retrigger, free-voice or steal.
module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    midi_command_ready,
    input  logic [3:0]              ch_message,
    input  logic [3:0]              chan,
    input  logic [6:0]              note,
    input  logic [6:0]              velocity,
    input  logic [6:0]              lsb,
    input  logic [3:0]              listen_chan,
    input  logic                    omni,
    output logic                    busy,
    output logic                    drop,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [NUM_VOICES-1:0]   voice_trig,
    output logic [7*NUM_VOICES-1:0] voice_note,
    output logic [7*NUM_VOICES-1:0] voice_vel,
    output logic                    steal
);

    localparam int IW = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
    typedef enum logic [1:0] {EV_ON, EV_OFF, EV_ALL} kind_t;

    state_t state_q, state_d;
    kind_t  kind_q, kind_d;
    logic   ready_q;
    logic [6:0] lnote_q, lnote_d;
    logic [6:0] lvel_q, lvel_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [NUM_VOICES-1:0] mmask_q, mmask_d;
    logic mfound_q, mfound_d;
    logic ffound_q, ffound_d;
    logic ofound_q, ofound_d;
    logic [IW-1:0] midx_q, midx_d;
    logic [IW-1:0] fidx_q, fidx_d;
    logic [IW-1:0] oidx_q, oidx_d;
    logic [AGE_W-1:0] oage_q, oage_d;

    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [NUM_VOICES-1:0] trig_q, trig_d;
    logic steal_q, steal_d;
    logic drop_q, drop_d;
    logic [6:0] note_q [NUM_VOICES];
    logic [6:0] note_d [NUM_VOICES];
    logic [6:0] vel_q [NUM_VOICES];
    logic [6:0] vel_d [NUM_VOICES];
    logic [AGE_W-1:0] age_q [NUM_VOICES];
    logic [AGE_W-1:0] age_d [NUM_VOICES];

    logic ev, is_on, is_off, is_all;
    logic [IW-1:0] tgt;

    assign ev     = midi_command_ready & ~ready_q
                  & (omni | (chan == listen_chan));
    assign is_on  = (ch_message == 4'h9) && (velocity != 7'd0);
    assign is_off = (ch_message == 4'h8)
                  || ((ch_message == 4'h9) && (velocity == 7'd0));
    assign is_all = (ch_message == 4'hB)
                  && ((lsb == 7'd120) || (lsb == 7'd123));

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        lnote_d  = lnote_q;
        lvel_d   = lvel_q;
        idx_d    = idx_q;
        mmask_d  = mmask_q;
        mfound_d = mfound_q;
        ffound_d = ffound_q;
        ofound_d = ofound_q;
        midx_d   = midx_q;
        fidx_d   = fidx_q;
        oidx_d   = oidx_q;
        oage_d   = oage_q;
        gate_d   = gate_q;
        note_d   = note_q;
        vel_d    = vel_q;
        age_d    = age_q;
        trig_d   = '0;
        steal_d  = 1'b0;
        drop_d   = 1'b0;
        tgt      = '0;

        unique case (state_q)
            IDLE: begin
                if (ev && (is_on || is_off)) begin
                    kind_d   = is_on ? EV_ON : EV_OFF;
                    lnote_d  = note;
                    lvel_d   = velocity;
                    idx_d    = '0;
                    mmask_d  = '0;
                    mfound_d = 1'b0;
                    ffound_d = 1'b0;
                    ofound_d = 1'b0;
                    state_d  = SCAN;
                end else if (ev && is_all) begin
                    kind_d  = EV_ALL;
                    state_d = COMMIT;
                end
            end
            SCAN: begin
                drop_d = ev;
                if (gate_q[idx_q] && (note_q[idx_q] == lnote_q)) begin
                    mmask_d[idx_q] = 1'b1;
                    if (!mfound_q) begin
                        mfound_d = 1'b1;
                        midx_d   = idx_q;
                    end
                end
                if (!gate_q[idx_q] && !ffound_q) begin
                    ffound_d = 1'b1;
                    fidx_d   = idx_q;
                end
                // strict '>' keeps the lowest index on equal ages
                if (gate_q[idx_q]
                    && (!ofound_q || (age_q[idx_q] > oage_q))) begin
                    ofound_d = 1'b1;
                    oidx_d   = idx_q;
                    oage_d   = age_q[idx_q];
                end
                if (idx_q == IW'(NUM_VOICES - 1)) begin
                    state_d = COMMIT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            COMMIT: begin
                drop_d  = ev;
                state_d = IDLE;
                unique case (kind_q)
                    EV_ON: begin
                        tgt = mfound_q ? midx_q
                            : (ffound_q ? fidx_q : oidx_q);
                        steal_d = !mfound_q && !ffound_q;
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if ((IW'(i) != tgt) && gate_q[i]
                                && (age_q[i] != '1)) begin
                                age_d[i] = age_q[i] + AGE_W'(1);
                            end
                        end
                        age_d[tgt]  = '0;
                        gate_d[tgt] = 1'b1;
                        note_d[tgt] = lnote_q;
                        vel_d[tgt]  = lvel_q;
                        trig_d[tgt] = 1'b1;
                    end
                    EV_OFF: begin
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (mmask_q[i]) begin
                                gate_d[i] = 1'b0;
                                age_d[i]  = '0;
                            end
                        end
                    end
                    EV_ALL: begin
                        gate_d = '0;
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            age_d[i] = '0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            kind_q   <= EV_ON;
            ready_q  <= 1'b0;
            lnote_q  <= '0;
            lvel_q   <= '0;
            idx_q    <= '0;
            mmask_q  <= '0;
            mfound_q <= 1'b0;
            ffound_q <= 1'b0;
            ofound_q <= 1'b0;
            midx_q   <= '0;
            fidx_q   <= '0;
            oidx_q   <= '0;
            oage_q   <= '0;
            gate_q   <= '0;
            trig_q   <= '0;
            steal_q  <= 1'b0;
            drop_q   <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                vel_q[i]  <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            ready_q  <= midi_command_ready;
            lnote_q  <= lnote_d;
            lvel_q   <= lvel_d;
            idx_q    <= idx_d;
            mmask_q  <= mmask_d;
            mfound_q <= mfound_d;
            ffound_q <= ffound_d;
            ofound_q <= ofound_d;
            midx_q   <= midx_d;
            fidx_q   <= fidx_d;
            oidx_q   <= oidx_d;
            oage_q   <= oage_d;
            gate_q   <= gate_d;
            trig_q   <= trig_d;
            steal_q  <= steal_d;
            drop_q   <= drop_d;
            note_q   <= note_d;
            vel_q    <= vel_d;
            age_q    <= age_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign drop       = drop_q;
    assign voice_gate = gate_q;
    assign voice_trig = trig_q;
    assign steal      = steal_q;

    always_comb begin
        voice_note = '0;
        voice_vel  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note[7*i +: 7] = note_q[i];
            voice_vel[7*i +: 7]  = vel_q[i];
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: scoreboard of expected commit results
// from a behavioural voice model, directed scenarios plus random events.
module tb_voice_allocator;

    localparam int NV   = 4;
    localparam int AW   = 4;
    localparam int AMAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ready = 1'b0;
    logic [3:0] ch_message = '0;
    logic [3:0] chan = '0;
    logic [6:0] note = '0;
    logic [6:0] velocity = '0;
    logic [6:0] lsb = '0;
    logic [3:0] listen_chan = '0;
    logic omni = 1'b1;
    logic busy, drop, steal;
    logic [NV-1:0] voice_gate, voice_trig;
    logic [7*NV-1:0] voice_note, voice_vel;

    voice_allocator #(.NUM_VOICES(NV), .AGE_W(AW)) dut (
        .clk(clk), .rst(rst), .midi_command_ready(ready),
        .ch_message(ch_message), .chan(chan), .note(note),
        .velocity(velocity), .lsb(lsb), .listen_chan(listen_chan),
        .omni(omni), .busy(busy), .drop(drop),
        .voice_gate(voice_gate), .voice_trig(voice_trig),
        .voice_note(voice_note), .voice_vel(voice_vel), .steal(steal)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [NV-1:0]   gate;
        logic [7*NV-1:0] notes;
        logic [7*NV-1:0] vels;
        logic [NV-1:0]   trig;
        logic            stl;
        int              blen;
    } exp_t;

    exp_t expq[$];
    exp_t cur;
    int checks = 0;
    int passed = 0;
    int m_gate[NV];
    int m_note[NV];
    int m_vel[NV];
    int m_age[NV];
    bit in_reset = 1'b0;
    int drop_cnt = 0;
    int trig0_cnt = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Monitor: every end of a busy period is a commit to compare.
    logic busy_p = 1'b0;
    int blen = 0;
    bit post = 1'b0;
    always @(negedge clk) begin
        if (drop) drop_cnt++;
        if (voice_trig[0]) trig0_cnt++;
        if (post) begin
            chk("pulse_clear", {63'd0, steal} | {60'd0, voice_trig}, 0);
            post = 1'b0;
        end
        if (busy) blen++;
        if (busy_p && !busy && !in_reset) begin
            if (expq.size() == 0) begin
                chk("unexpected_commit", 1, 0);
            end else begin
                cur = expq.pop_front();
                chk("gate", voice_gate, cur.gate);
                chk("notes", voice_note, cur.notes);
                chk("vels", voice_vel, cur.vels);
                chk("trig", voice_trig, cur.trig);
                chk("steal", steal, cur.stl);
                chk("busy_len", blen, cur.blen);
                post = 1'b1;
            end
        end
        if (!busy) blen = 0;
        busy_p = busy;
    end

    function automatic void model_clear();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
        end
    endfunction

    function automatic void model(input logic [3:0] m, input logic [3:0] c,
                                  input logic [6:0] n, input logic [6:0] v,
                                  input logic [6:0] l);
        exp_t e;
        bit on, off, all;
        int t, best;
        if (!(omni || c == listen_chan)) return;
        on  = (m == 4'h9) && (v != 0);
        off = (m == 4'h8) || ((m == 4'h9) && (v == 0));
        all = (m == 4'hB) && (l == 120 || l == 123);
        if (!(on || off || all)) return;
        e.trig = '0;
        e.stl  = 1'b0;
        e.blen = all ? 1 : NV + 1;
        if (on) begin
            t = -1;
            for (int i = 0; i < NV; i++)
                if (t < 0 && m_gate[i] == 1 && m_note[i] == int'(n)) t = i;
            for (int i = 0; i < NV; i++)
                if (t < 0 && m_gate[i] == 0) t = i;
            if (t < 0) begin
                best = -1;
                for (int i = 0; i < NV; i++)
                    if (m_age[i] > best) begin best = m_age[i]; t = i; end
                e.stl = 1'b1;
            end
            for (int i = 0; i < NV; i++)
                if (i != t && m_gate[i] == 1 && m_age[i] < AMAX) m_age[i]++;
            m_age[t]  = 0;
            m_gate[t] = 1;
            m_note[t] = int'(n);
            m_vel[t]  = int'(v);
            e.trig[t] = 1'b1;
        end else if (off) begin
            for (int i = 0; i < NV; i++)
                if (m_gate[i] == 1 && m_note[i] == int'(n)) begin
                    m_gate[i] = 0; m_age[i] = 0;
                end
        end else begin
            for (int i = 0; i < NV; i++) begin m_gate[i] = 0; m_age[i] = 0; end
        end
        for (int i = 0; i < NV; i++) begin
            e.gate[i]        = m_gate[i][0];
            e.notes[7*i +: 7] = 7'(m_note[i]);
            e.vels[7*i +: 7]  = 7'(m_vel[i]);
        end
        expq.push_back(e);
    endfunction

    task automatic pulse(input logic [3:0] m, input logic [3:0] c,
                         input logic [6:0] n, input logic [6:0] v,
                         input logic [6:0] l);
        @(negedge clk);
        ch_message = m; chan = c; note = n; velocity = v; lsb = l;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 40) begin @(negedge clk); k++; end
        if (busy) chk("idle_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] m, input logic [3:0] c,
                        input logic [6:0] n, input logic [6:0] v,
                        input logic [6:0] l);
        model(m, c, n, v, l);
        pulse(m, c, n, v, l);
        wait_idle();
    endtask

    task automatic do_reset();
        in_reset = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;
        model_clear();
    endtask

    task automatic chk_zero(input string name);
        chk(name, {busy, drop, steal, voice_gate, voice_trig}, 0);
        chk({name, "_nv"}, {voice_note, voice_vel}, 0);
    endtask

    int t0, d0, r;
    logic [6:0] rn, rv;
    logic [3:0] rc;

    initial begin
        model_clear();
        in_reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset_state");
        rst = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;

        t0 = trig0_cnt;
        send(4'h9, 0, 60, 100, 0);
        chk("t1_gate", voice_gate, 4'b0001);
        chk("t1_note", voice_note[6:0], 60);
        chk("t1_vel", voice_vel[6:0], 100);
        chk("t1_trig", trig0_cnt - t0, 1);

        do_reset();
        send(4'h9, 0, 60, 100, 0);
        send(4'h9, 0, 62, 100, 0);
        send(4'h9, 0, 64, 100, 0);
        send(4'h9, 0, 65, 100, 0);
        send(4'h9, 0, 67, 100, 0);
        chk("t2_gate", voice_gate, 4'b1111);
        chk("t2_note0", voice_note[6:0], 67);

        do_reset();
        send(4'h9, 0, 60, 100, 0);
        send(4'h9, 0, 62, 100, 0);
        send(4'h9, 0, 60, 0, 0);
        chk("t3_gate", voice_gate, 4'b0010);
        chk("t3_note0", voice_note[6:0], 60);
        send(4'h9, 0, 70, 100, 0);
        chk("t3_note0b", voice_note[6:0], 70);

        do_reset();
        t0 = trig0_cnt;
        send(4'h9, 0, 60, 50, 0);
        send(4'h9, 0, 60, 90, 0);
        chk("t4_gate", voice_gate, 4'b0001);
        chk("t4_vel", voice_vel[6:0], 90);
        chk("t4_trigs", trig0_cnt - t0, 2);

        do_reset();
        d0 = drop_cnt;
        model(4'h9, 0, 72, 80, 0);
        pulse(4'h9, 0, 72, 80, 0);
        pulse(4'h9, 0, 74, 80, 0);
        wait_idle();
        chk("t5_drop", drop_cnt - d0, 1);
        chk("t5_gate", voice_gate, 4'b0001);
        send(4'hB, 0, 0, 0, 123);
        chk("t5_alloff", voice_gate, 4'b0000);

        omni = 1'b0;
        listen_chan = 4'd9;
        pulse(4'h9, 3, 60, 100, 0);
        chk("t6_ignored", busy, 0);
        @(negedge clk);
        chk("t6_ignored2", busy, 0);
        send(4'h9, 9, 61, 100, 0);
        chk("t6_accept", voice_gate, 4'b0001);

        pulse(4'h9, 9, 62, 100, 0);
        @(negedge clk);
        chk("t7_scanning", busy, 1);
        in_reset = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("t7_midscan_reset");
        rst = 1'b1;
        @(negedge clk);
        in_reset = 1'b0;
        model_clear();
        send(4'h9, 9, 63, 100, 0);
        chk("t7_gate", voice_gate, 4'b0001);
        chk("t7_note", voice_note[6:0], 63);

        omni = 1'b1;
        for (int k = 0; k < 200; k++) begin
            r  = $urandom_range(0, 9);
            rn = 7'(60 + $urandom_range(0, 6));
            rv = 7'($urandom_range(1, 127));
            rc = 4'($urandom_range(0, 15));
            case (r)
                0, 1, 2, 3, 4: send(4'h9, rc, rn, rv, 0);
                5: send(4'h8, rc, rn, rv, 0);
                6: send(4'h9, rc, rn, 0, 0);
                7: send(4'hB, rc, 0, 0,
                        ($urandom_range(0, 2) == 0) ? 7'd7
                        : (($urandom_range(0, 1) == 0) ? 7'd120 : 7'd123));
                8: send(4'hC, rc, rn, rv, 0);
                default: begin
                    omni = 1'b0;
                    send(4'h9, rc, rn, rv, 0);
                    omni = 1'b1;
                end
            endcase
        end

        chk("queue_empty", expq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice scheduler between the MIDI receiver and the NUM_VOICES synthesis voices.
- Consumes decoded channel messages (ready pulse, ch_message, chan, note, velocity, lsb) and assigns note-ons to voices.
- Note-ons retrigger a voice already holding the same note, else take a free voice, else steal the oldest.
- Releases voices on note-off and on all-notes-off controllers.

Parameters:
- NUM_VOICES, 8, number of voices (2..16).
- AGE_W, 4, width of per-voice age counter; must satisfy 2^AGE_W >= NUM_VOICES.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-low reset
- midi_command_ready  in  1  message-complete strobe from the MIDI receiver
- ch_message  in  4  status high nibble
- chan  in  4  message channel, 0..15
- note  in  7  note number
- velocity  in  7  note velocity
- lsb  in  7  controller number for 0xB messages
- listen_chan  in  4  channel to respond to
- omni  in  1  1 = respond to all channels
- busy  out  1  allocator processing an event
- drop  out  1  one-cycle pulse: event arrived while busy, discarded
- voice_gate  out  NUM_VOICES  per-voice gate; 1 = note held
- voice_trig  out  NUM_VOICES  one-cycle pulse per voice on (re)trigger
- voice_note  out  7*NUM_VOICES  packed note per voice; voice i at [7i+6:7i]
- voice_vel  out  7*NUM_VOICES  packed velocity per voice, same packing
- steal  out  1  one-cycle pulse when a held voice was stolen

Behaviour:
- Reset (rst=0 at a clk edge):
  - All outputs 0; ages 0; FSM to IDLE; pending event discarded.
  - Also applies mid-scan.
- Event detect:
  - Rising edge of midi_command_ready (registered previous value), sampled at clk.
  - Channel must pass the filter: omni=1 or chan==listen_chan. Otherwise ignored, no drop.
- Classification, latched at acceptance:
  - ON: ch_message=0x9 and velocity!=0.
  - OFF: ch_message=0x8, or 0x9 with velocity=0.
  - ALLOFF: ch_message=0xB and lsb in {120, 123}.
  - Anything else: ignored, FSM stays IDLE.
- Busy-time events: a valid event edge seen while FSM!=IDLE is discarded and drop pulses 1 cycle.
- FSM states: IDLE, SCAN, COMMIT.
  - IDLE: on a classified ON/OFF, latch the fields, set idx=0, go to SCAN. On ALLOFF, go directly to COMMIT.
  - SCAN, one voice per cycle, idx 0..NUM_VOICES-1:
    - match_mask[idx] = gate[idx] && note[idx]==latched note.
    - first_match = lowest matching idx.
    - first_free = lowest idx with gate=0.
    - oldest = gated voice with maximum age, lowest idx on tie.
    - After idx=NUM_VOICES-1, go to COMMIT.
  - COMMIT: one cycle, then IDLE.
- busy = 1 whenever FSM!=IDLE.
- Latency: accept edge E0, scan edges E1..E_N, commit edge E_{N+1}. Outputs update at E_{N+1}; busy low after E_{N+1}. ALLOFF commits at E1.
- COMMIT actions:
  - ON: target = first_match if any, else first_free if any, else oldest.
    - Set gate[t]=1, note[t], vel[t].
    - voice_trig[t] pulses for exactly 1 cycle.
    - steal pulses 1 cycle only in the oldest case.
    - Ages: age[t]=0; every other gated voice increments, saturating at 2^AGE_W-1.
  - OFF: gate cleared and age zeroed on every voice in match_mask. note/vel retained for envelope release. No match = no change.
  - ALLOFF: all gates 0, all ages 0; note/vel retained.
- Voice state changes only at COMMIT.

Test Plan (NUM_VOICES=4, omni=1):
- Reset, then ON note 60 vel 100 → after 6 cycles: gate=0001, voice_note[6:0]=60, vel=100, trig=0001 for 1 cycle, busy high 5 cycles.
- ON 60, 62, 64, 65, then ON 67 → gate=1111; voice0 (oldest) becomes note 67; steal and trig[0] pulse.
- Notes 60, 62 held; 0x9 note 60 vel 0 → gate=0010; voice0 note stays 60. Then ON 70 → lands in voice0.
- ON 60 vel 50, then ON 60 vel 90 → single voice0 retriggered: gate=0001, vel=90, trig[0] pulses twice total.
- Two ready edges 2 cycles apart → second gives drop pulse, no state change. Then CC lsb=123 → gate=0000 one cycle after acceptance.
- omni=0, listen_chan=9, ON on chan 3 → ignored, busy stays 0. rst=0 mid-SCAN → all outputs 0, next event processed normally.
